// File: rtl/regfile_arb_pkg.sv
// Shared widths, FSM encoding and index helper for the register-file write arbiter.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int BEAT_CNT_W = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_e;

    // Requester index that follows idx, wrapping back to 0 after n-1.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way round-robin picker: first set request at or after ptr, modulo N.
module rr_pick #(
    parameter int N = 3,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N; k++) begin
            cand = IDX_W'((int'(ptr) + k) % N);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port, with bounded atomic
// lock bursts and a registered write stage that drives the register file directly.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int N        = 3,
    parameter int LOCK_MAX = 4,
    localparam int IDX_W   = $clog2(N)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [N-1:0]            ReqValid,
    input  logic [REG_ADDR_W*N-1:0] ReqReg,
    input  logic [DATA_W*N-1:0]     ReqData,
    input  logic [N-1:0]            ReqLock,
    output logic [N-1:0]            ReqReady,
    output logic                    RegWrite,
    output logic [REG_ADDR_W-1:0]   WriteReg,
    output logic [DATA_W-1:0]       WriteData,
    output logic                    Busy,
    output logic [IDX_W-1:0]        LockOwner
);

    localparam logic [BEAT_CNT_W-1:0] LOCK_LIMIT = BEAT_CNT_W'(LOCK_MAX);
    localparam logic                  LOCK_ALLOWED = (LOCK_MAX > 1);

    arb_state_e              state_reg, state_next;
    logic [IDX_W-1:0]        ptr_reg, ptr_next;
    logic [IDX_W-1:0]        owner_reg, owner_next;
    logic [BEAT_CNT_W-1:0]   beat_cnt_reg, beat_cnt_next;
    logic [BEAT_CNT_W-1:0]   beat_inc;

    logic                    reg_write_reg;
    logic [REG_ADDR_W-1:0]   write_reg_reg;
    logic [DATA_W-1:0]       write_data_reg;

    logic [N-1:0]            pick_grant;
    logic [IDX_W-1:0]        pick_idx;
    logic [N-1:0]            grant;
    logic [IDX_W-1:0]        grant_idx;
    logic                    accept;
    logic [N-1:0]            owner_onehot;

    logic [REG_ADDR_W-1:0]   req_reg_arr  [N];
    logic [DATA_W-1:0]       req_data_arr [N];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign req_reg_arr[gi]  = ReqReg[gi*REG_ADDR_W +: REG_ADDR_W];
            assign req_data_arr[gi] = ReqData[gi*DATA_W +: DATA_W];
            assign owner_onehot[gi] = (owner_reg == IDX_W'(gi));
        end
    endgenerate

    rr_pick #(.N(N)) u_pick (
        .req   (ReqValid),
        .ptr   (ptr_reg),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // While locked only the owner can be granted; everyone else simply waits.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (!rst) begin
            if (state_reg == ST_IDLE) begin
                grant     = pick_grant;
                grant_idx = pick_idx;
            end else begin
                grant     = ReqValid & owner_onehot;
                grant_idx = owner_reg;
            end
        end
    end

    assign ReqReady = grant;
    assign accept   = |grant;
    assign beat_inc = beat_cnt_reg + BEAT_CNT_W'(1);

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        owner_next    = owner_reg;
        beat_cnt_next = beat_cnt_reg;
        if (accept) begin
            if (state_reg == ST_IDLE) begin
                ptr_next = IDX_W'(wrap_inc(int'(grant_idx), N));
                if (ReqLock[grant_idx] && LOCK_ALLOWED) begin
                    state_next    = ST_LOCKED;
                    owner_next    = grant_idx;
                    beat_cnt_next = BEAT_CNT_W'(1);
                end
            end else if (!ReqLock[grant_idx] || beat_inc == LOCK_LIMIT) begin
                // Forced release still writes this beat; it is simply the last one.
                state_next    = ST_IDLE;
                ptr_next      = IDX_W'(wrap_inc(int'(owner_reg), N));
                beat_cnt_next = '0;
            end else begin
                beat_cnt_next = beat_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            owner_reg      <= '0;
            beat_cnt_reg   <= '0;
            reg_write_reg  <= 1'b0;
            write_reg_reg  <= '0;
            write_data_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            owner_reg    <= owner_next;
            beat_cnt_reg <= beat_cnt_next;
            if (accept) begin
                // r0 beats are consumed but never reach the register file.
                reg_write_reg  <= (req_reg_arr[grant_idx] != '0);
                write_reg_reg  <= req_reg_arr[grant_idx];
                write_data_reg <= req_data_arr[grant_idx];
            end else begin
                reg_write_reg <= 1'b0;
            end
        end
    end

    assign RegWrite  = reg_write_reg;
    assign WriteReg  = write_reg_reg;
    assign WriteData = write_data_reg;
    assign Busy      = (state_reg == ST_LOCKED);
    assign LockOwner = owner_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed plus random bench for regfile_write_arbiter against a behavioural arbitration model.
module tb_regfile_write_arbiter;

    localparam int N        = 3;
    localparam int LOCK_MAX = 4;
    localparam int IDX_W    = $clog2(N);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      ReqValid = '0;
    logic [5*N-1:0]    ReqReg   = '0;
    logic [32*N-1:0]   ReqData  = '0;
    logic [N-1:0]      ReqLock  = '0;
    logic [N-1:0]      ReqReady;
    logic              RegWrite;
    logic [4:0]        WriteReg;
    logic [31:0]       WriteData;
    logic              Busy;
    logic [IDX_W-1:0]  LockOwner;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: lock flag, owner, rotation start, beats in current lock, expected outputs.
    bit          m_locked = 0;
    int          m_owner  = 0;
    int          m_ptr    = 0;
    int          m_cnt    = 0;
    logic        e_we     = 1'b0;
    logic [4:0]  e_reg    = '0;
    logic [31:0] e_data   = '0;
    logic [N-1:0] obs_ready = '0;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.N(N), .LOCK_MAX(LOCK_MAX)) dut (
        .clk       (clk),
        .rst       (rst),
        .ReqValid  (ReqValid),
        .ReqReg    (ReqReg),
        .ReqData   (ReqData),
        .ReqLock   (ReqLock),
        .ReqReady  (ReqReady),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .Busy      (Busy),
        .LockOwner (LockOwner)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int i, input logic v, input logic [4:0] r,
                           input logic [31:0] d, input logic l);
        ReqValid[i]        = v;
        ReqReg[i*5 +: 5]   = r;
        ReqData[i*32 +: 32] = d;
        ReqLock[i]         = l;
    endtask

    function automatic int model_grant();
        if (rst) return -1;
        if (m_locked) return ReqValid[m_owner] ? m_owner : -1;
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (ReqValid[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check Ready mid-cycle, then check the registered outputs just after the edge.
    task automatic step();
        int g;
        @(negedge clk);
        g = model_grant();
        obs_ready = ReqReady;
        chk("ready", {29'd0, ReqReady}, (g >= 0) ? (32'd1 << g) : 32'd0);
        @(posedge clk);
        #1;
        if (rst) begin
            m_locked = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
            e_we = 1'b0; e_reg = '0; e_data = '0;
        end else if (g >= 0) begin
            e_reg  = ReqReg[g*5 +: 5];
            e_data = ReqData[g*32 +: 32];
            e_we   = (e_reg != 0);
            if (!m_locked) begin
                m_ptr = (g + 1) % N;
                if (ReqLock[g] && LOCK_MAX > 1) begin
                    m_locked = 1; m_owner = g; m_cnt = 1;
                end
            end else begin
                m_cnt++;
                if (!ReqLock[g] || m_cnt == LOCK_MAX) begin
                    m_locked = 0; m_ptr = (g + 1) % N; m_cnt = 0;
                end
            end
        end else begin
            e_we = 1'b0;
        end
        chk("regwrite", {31'd0, RegWrite}, {31'd0, e_we});
        chk("writereg", {27'd0, WriteReg}, {27'd0, e_reg});
        chk("writedata", WriteData, e_data);
        chk("busy", {31'd0, Busy}, m_locked ? 32'd1 : 32'd0);
        chk("lockowner", {30'd0, LockOwner}, m_owner);
    endtask

    initial begin
        // 1: reset then idle
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        step();
        chk("t1_regwrite", {31'd0, RegWrite}, 32'd0);
        chk("t1_busy", {31'd0, Busy}, 32'd0);

        // 2: plain round robin over three requesters
        set_req(0, 1'b1, 5'd1, 32'hAAAA_0001, 1'b0);
        set_req(1, 1'b1, 5'd2, 32'hBBBB_0002, 1'b0);
        set_req(2, 1'b1, 5'd3, 32'hCCCC_0003, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("t2_grant", {29'd0, obs_ready}, 32'd1 << (k % 3));
            chk("t2_wreg", {27'd0, WriteReg}, (k % 3) + 1);
            chk("t2_we", {31'd0, RegWrite}, 32'd1);
        end

        // 3: beat to r0 is consumed without a write
        set_req(0, 1'b0, 5'd0, 32'd0, 1'b0);
        set_req(2, 1'b0, 5'd0, 32'd0, 1'b0);
        set_req(1, 1'b1, 5'd0, 32'hDEAD, 1'b0);
        step();
        chk("t3_ready", {29'd0, obs_ready}, 32'd2);
        chk("t3_we", {31'd0, RegWrite}, 32'd0);
        chk("t3_data", WriteData, 32'hDEAD);

        // 4: three-beat lock burst from requester 2 while requester 0 waits
        set_req(1, 1'b0, 5'd0, 32'd0, 1'b0);
        set_req(0, 1'b1, 5'd8, 32'h0000_0808, 1'b0);
        set_req(2, 1'b1, 5'd5, 32'h0000_0055, 1'b1);
        step();
        chk("t4_b1", {29'd0, obs_ready}, 32'd4);
        chk("t4_busy1", {31'd0, Busy}, 32'd1);
        set_req(2, 1'b1, 5'd6, 32'h0000_0066, 1'b1);
        step();
        chk("t4_b2", {29'd0, obs_ready}, 32'd4);
        chk("t4_busy2", {31'd0, Busy}, 32'd1);
        set_req(2, 1'b1, 5'd7, 32'h0000_0077, 1'b0);
        step();
        chk("t4_b3", {29'd0, obs_ready}, 32'd4);
        chk("t4_busy3", {31'd0, Busy}, 32'd0);
        chk("t4_wreg3", {27'd0, WriteReg}, 32'd7);
        set_req(2, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        chk("t4_next", {29'd0, obs_ready}, 32'd1);

        // 5: forced release after LOCK_MAX beats
        set_req(0, 1'b1, 5'd9, 32'h0000_0900, 1'b1);
        step();
        chk("t5_b1", {29'd0, obs_ready}, 32'd1);
        set_req(1, 1'b1, 5'd10, 32'h0000_0A00, 1'b0);
        for (int k = 2; k <= LOCK_MAX; k++) begin
            step();
            chk("t5_beat", {29'd0, obs_ready}, 32'd1);
        end
        chk("t5_release", {31'd0, Busy}, 32'd0);
        step();
        chk("t5_req1", {29'd0, obs_ready}, 32'd2);
        set_req(1, 1'b0, 5'd0, 32'd0, 1'b0);
        step();
        chk("t5_reacq", {29'd0, obs_ready}, 32'd1);
        chk("t5_busy", {31'd0, Busy}, 32'd1);

        // 6: reset during a lock
        step();
        rst = 1'b1;
        step();
        chk("t6_busy", {31'd0, Busy}, 32'd0);
        chk("t6_we", {31'd0, RegWrite}, 32'd0);
        rst = 1'b0;
        set_req(1, 1'b1, 5'd11, 32'h0000_0B00, 1'b0);
        step();
        chk("t6_restart", {29'd0, obs_ready}, 32'd1);

        // Random traffic; requesters hold their request until it is accepted
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(63) == 0);
            for (int i = 0; i < N; i++) begin
                if (!ReqValid[i] || obs_ready[i]) begin
                    if ($urandom_range(3) != 0)
                        set_req(i, 1'b1, 5'($urandom_range(31)), $urandom, ($urandom_range(2) != 0));
                    else
                        set_req(i, 1'b0, 5'd0, 32'd0, 1'b0);
                end
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single register-file write port (RegWrite/WriteReg/WriteData) between N writeback requesters, for example the ALU result path, the load path and a multi-cycle mul/div unit.
- Arbitration is round-robin per beat.
- A requester may hold an atomic lock for back-to-back beats, such as a multi-register load. The lock is bounded by LOCK_MAX beats.
- Output is registered and drives the register file directly.

Parameters:
N, 3, number of requesters (2..8)
LOCK_MAX, 4, max consecutive beats one lock holder may issue before forced release (1..15)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  reset, synchronous, active-high
ReqValid  in  N  per-requester write request
ReqReg  in  5*N  dest register, requester i in bits [5i+4:5i]
ReqData  in  32*N  write data, requester i in bits [32i+31:32i]
ReqLock  in  N  hold the grant after this beat
ReqReady  out  N  one-hot or zero; beat i accepted when ReqValid[i] & ReqReady[i]
RegWrite  out  1  register-file write enable
WriteReg  out  5  register-file write address
WriteData  out  32  register-file write data
Busy  out  1  1 while in LOCKED state
LockOwner  out  clog2(N)  owner index; valid when Busy=1

Behaviour:
- Clock and reset: one clock (clk); reset rst is synchronous, active-high.
- State: ST_IDLE, ST_LOCKED. Also Ptr (clog2(N) bits), Owner (clog2(N) bits) and BeatCnt (4 bits).
- Reset values on the clk edge with rst=1:
  - state=ST_IDLE, Ptr=0, Owner=0, BeatCnt=0.
  - RegWrite=0, WriteReg=0, WriteData=0.
  - Busy=0, LockOwner=0.
  - ReqReady is forced 0 while rst=1 (combinational gate).
- ReqReady is combinational (Mealy) from state, Ptr, Owner and ReqValid.
- Requesters hold Valid/Reg/Data/Lock stable until accepted. Ready never depends on ReqReg or ReqData.
- ST_IDLE:
  - Grant the first i with ReqValid[i]=1, searching Ptr, Ptr+1, ... mod N.
  - No valid requests: ReqReady=0.
  - On an accepted beat i: Ptr <= (i+1) mod N.
  - If ReqLock[i]=1 and LOCK_MAX>1: go to ST_LOCKED, Owner<=i, BeatCnt<=1.
- ST_LOCKED:
  - Only Owner may receive ReqReady. Other valid requests wait.
  - Owner valid low: no grant, stay locked, no write issued.
  - Owner beat accepted: BeatCnt<=BeatCnt+1.
  - Exit to ST_IDLE, with Ptr<=(Owner+1) mod N and BeatCnt<=0, when the accepted beat has ReqLock=0, or when BeatCnt+1==LOCK_MAX (forced release; that beat is still written).
- Output stage, latency exactly 1 cycle after acceptance:
  - WriteReg<=ReqReg[g] and WriteData<=ReqData[g].
  - RegWrite<=1 only if ReqReg[g]!=0.
  - A beat to r0 is accepted (Ready=1) and consumed, but RegWrite stays 0.
  - Cycle with no accepted beat: RegWrite<=0; WriteReg/WriteData hold their previous values.
- Throughput: one beat per cycle, sustained, with no bubble between grants.
- Reset mid-lock: on the next edge, return to ST_IDLE with all outputs at reset values. The pending output beat is dropped.
- Busy = (state==ST_LOCKED); LockOwner = Owner.

Decomposition:
- Package regfile_arb_pkg holds:
  - REG_ADDR_W=5, DATA_W=32.
  - State encoding ST_IDLE/ST_LOCKED.
  - BEAT_CNT_W=4.
- One sub-module: rr_pick. It is a combinational N-way round-robin picker with inputs req[N-1:0] and ptr, and outputs onehot grant and an index. It is instantiated once.
- FSM, counters and output register live in the top module.

Test Plan:
1. Reset then idle: rst=1 for 2 cycles, then ReqValid=0 -> RegWrite=0, WriteReg=0, WriteData=0, ReqReady=0, Busy=0 throughout.
2. Round robin: ReqValid=3'b111, no locks, regs 1/2/3 with data A/B/C, held 6 cycles -> grants 0,1,2,0,1,2. The next-cycle write sequence is reg1=A, reg2=B, reg3=C, repeating, with RegWrite=1 every cycle.
3. Zero register: requester 1 sends ReqReg=0, data 32'hDEAD -> ReqReady[1]=1 that cycle; next cycle RegWrite=0 and WriteData=32'hDEAD.
4. Lock burst: requester 2 sends 3 beats with Lock=1,1,0 to regs 5,6,7 while req0 is also valid -> req0 is not granted until after the third beat. Busy=1 on the cycles after beats 1 and 2. Next grant goes to req0 (Ptr=0).
5. Forced release: LOCK_MAX=4, requester 0 holds Lock=1 for 6 beats with req1 valid -> exactly 4 beats from req0 are written, then req1 is granted, then req0 can re-acquire.
6. Reset mid-lock: rst asserted for one cycle during beat 2 of a lock -> next cycle Busy=0, RegWrite=0, Ptr=0; arbitration restarts from requester 0.
